// File: rtl/msrv32_pipe_pkg.sv
// Shared widths and state encoding for the msrv32 pipeline registers.
package msrv32_pipe_pkg;

    localparam int RD_W       = 5;
    localparam int CSR_ADDR_W = 12;
    localparam int XLEN       = 32;
    localparam int ALU_OP_W   = 4;
    localparam int LS_W       = 2;
    localparam int WB_SEL_W   = 3;
    localparam int CSR_OP_W   = 3;

    // Six XLEN-wide fields: rs1, rs2, pc, pc_plus_4, iadder, imm.
    localparam int STAGE2_DATA_W = RD_W + CSR_ADDR_W + 6 * XLEN + ALU_OP_W
                                 + LS_W + WB_SEL_W + CSR_OP_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/msrv32_pipe_reg_hs_if.sv
// Valid/ready bundle between two msrv32 pipeline stages.
interface msrv32_pipe_reg_hs_if #(
    parameter int DATA_W = msrv32_pipe_pkg::STAGE2_DATA_W,
    parameter int CTRL_W = 2,
    parameter int CNT_W  = 16
);
    logic              in_valid_in;
    logic              in_ready_out;
    logic [DATA_W-1:0] data_in;
    logic [CTRL_W-1:0] ctrl_in;
    logic              flush_in;
    logic              out_valid_out;
    logic              out_ready_in;
    logic [DATA_W-1:0] data_out;
    logic [CTRL_W-1:0] ctrl_out;
    logic [CNT_W-1:0]  stall_cnt_out;
    logic              clr_cnt_in;

    modport slave (
        input  in_valid_in, data_in, ctrl_in, flush_in, out_ready_in, clr_cnt_in,
        output in_ready_out, out_valid_out, data_out, ctrl_out, stall_cnt_out
    );

    modport master (
        output in_valid_in, data_in, ctrl_in, flush_in, out_ready_in, clr_cnt_in,
        input  in_ready_out, out_valid_out, data_out, ctrl_out, stall_cnt_out
    );

endinterface

// File: rtl/msrv32_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module msrv32_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/msrv32_pipe_reg_hs.sv
// Handshaked msrv32 pipeline register with optional 2-entry skid buffer,
// branch flush and a saturating stall-cycle counter.
module msrv32_pipe_reg_hs
    import msrv32_pipe_pkg::*;
#(
    parameter int DATA_W  = STAGE2_DATA_W,
    parameter int CTRL_W  = 2,
    parameter bit SKID_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    msrv32_pipe_reg_hs_if.slave  bus
);

    skid_state_e       r_state;
    skid_state_e       w_state_nxt;
    logic              r_in_ready;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic              w_main_valid;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;
    logic              w_load_main;
    logic              w_load_skid;
    logic              w_main_from_skid;
    logic              w_stall_inc;

    assign w_main_valid = (r_state != EMPTY);
    // Without the skid slot, ONE + input-only can never occur because ready drops.
    assign w_in_ready   = SKID_EN ? r_in_ready : (bus.out_ready_in | ~w_main_valid);
    assign w_in_xfer    = bus.in_valid_in & w_in_ready;
    assign w_out_xfer   = w_main_valid & bus.out_ready_in;
    assign w_stall_inc  = w_main_valid & ~bus.out_ready_in;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (bus.flush_in) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt = ONE;
                        w_load_main = 1'b1;
                    end
                end
                ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_load_main = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt      = ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            if (w_load_main) begin
                r_main_data <= bus.data_in;
                r_main_ctrl <= bus.ctrl_in;
            end else if (w_main_from_skid) begin
                r_main_data <= r_skid_data;
                r_main_ctrl <= r_skid_ctrl;
            end
            if (w_load_skid) begin
                r_skid_data <= bus.data_in;
                r_skid_ctrl <= bus.ctrl_in;
            end
        end
    end

    msrv32_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .i_inc    (w_stall_inc),
        .i_clr    (bus.clr_cnt_in),
        .o_cnt    (bus.stall_cnt_out)
    );

    // Write enables are masked on bubbles so a flushed or empty slot never writes.
    assign bus.in_ready_out  = w_in_ready;
    assign bus.out_valid_out = w_main_valid;
    assign bus.data_out      = r_main_data;
    assign bus.ctrl_out      = w_main_valid ? r_main_ctrl : '0;

endmodule
